ins_mem_loader: RTL
===================

# ins_mem_loader

Program loader that fills the instruction memory before the cores run. It accepts a length-prefixed, checksummed byte stream on a valid/ready interface and writes each byte through the memory's synchronous write port (wren/address/data). It then reads the written range back through the registered read port (q, 1-cycle latency) and reports done or error. It sits between the host byte receiver and the instruction memory; cores are held off until `done`.

## Interface

- DATA_WIDTH, 8, width of stream bytes and memory words
- ADDR_WIDTH, 8, memory address width; must equal DATA_WIDTH
- BASE_ADDR, 0, first memory address written

- clock  in  1  rising-edge clock
- rstN  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle arm pulse; honoured only in IDLE, DONE or ERROR
- in_valid  in  1  stream byte valid
- in_data  in  DATA_WIDTH  stream byte
- in_ready  out  1  loader accepts byte; transfer when in_valid && in_ready
- mem_wren  out  1  memory write enable
- mem_address  out  ADDR_WIDTH  memory address
- mem_data  out  DATA_WIDTH  memory write data
- mem_q  in  DATA_WIDTH  memory read data, valid the cycle after its address was driven
- busy  out  1  high in LEN, DATA, CSUM, VERIFY
- done  out  1  sticky success flag
- error  out  1  sticky failure flag

## Operation

- States: IDLE, LEN, DATA, CSUM, VERIFY, DONE, ERROR.
- IDLE/DONE/ERROR + start → LEN. Entering LEN clears done, error, index, sums. start is ignored while busy.
- LEN: in_ready=1. Accepted byte is N.
  - N=0 → ERROR; no writes occur.
  - Otherwise store N → DATA.
- DATA: in_ready=1. Accepted byte i (0..N-1) is handled as follows:
  - Next cycle: mem_wren=1 for exactly one cycle, mem_address=BASE_ADDR+i (mod 2^ADDR_WIDTH), mem_data=byte.
  - wsum += byte (mod 2^DATA_WIDTH).
  - After byte N-1 → CSUM.
- CSUM: in_ready=1. Accepted byte is stored as rx_csum → VERIFY.
- VERIFY: in_ready=0, mem_wren=0.
  - On VERIFY cycle k (0..N-1), drive mem_address=BASE_ADDR+k.
  - On cycles 1..N, add mem_q to vsum.
  - At the end of cycle N: if vsum==wsum and wsum==rx_csum → DONE, else → ERROR.
- DONE: done=1. ERROR: error=1. Both hold until start or reset.
- in_ready is decoded from state. in_data is ignored when the handshake does not complete.
- Reset at any point: all outputs go to reset values immediately and the state returns to IDLE. Memory contents are unspecified, possibly partially written.

## Timing

- Reset values: in_ready=0, mem_wren=0, mem_address=0, mem_data=0, busy=0, done=0, error=0; state IDLE.
- mem_wren, mem_address and mem_data are registered.
- Write latency: 1 cycle from accept edge to mem_wren high.
- Back-to-back accepts give back-to-back writes. Gaps in in_valid give mem_wren=0 cycles.
- Earliest CSUM accept coincides with the commit edge of the last write. VERIFY starts the cycle after, so the readback always sees committed data.
- VERIFY lasts N+1 cycles. done/error rises on cycle N+1 after the CSUM accept edge.
- LEN → ERROR on N=0: error is high the cycle after the accept.
- Address wraps modulo 2^ADDR_WIDTH; no overflow flag.

## Structure

- Shared package/header: state encodings (7 states, 3-bit), and the DATA_WIDTH/ADDR_WIDTH defaults shared with the instruction memory.
- Single module: FSM, index counter, length register, two accumulators. No sub-module is warranted.
- The bench instantiates the real instruction memory on the mem_* ports.

## Test plan

- Basic load: start; stream 0x03, 0x12, 0x34, 0x56, 0x9C with no gaps → writes (0x00,0x12), (0x01,0x34), (0x02,0x56) on consecutive cycles. done=1 four cycles after the CSUM accept; error=0; memory holds those values.
- Bad checksum: same stream with CSUM 0x9D → memory is still written; error=1 after VERIFY; done=0.
- Zero length: start; stream 0x00 → no mem_wren; error=1 next cycle; a following start then a valid stream → done=1.
- Wrap and backpressure: BASE_ADDR=0xFE; N=4, bytes 1,2,3,4, CSUM 0x0A, with random in_valid gaps → writes at 0xFE, 0xFF, 0x00, 0x01 only on accept+1 cycles; done=1.
- Readback corruption: the bench forces one memory location to a different value between the write and VERIFY → error=1.
- Reset and start rules: a start pulse in DATA is ignored; rstN low mid-DATA → outputs return to reset values asynchronously; after release, a full load succeeds from IDLE.

Source files
------------

// File: rtl/ins_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader FSM encoding and the
// word/address widths it shares with the instruction memory.
package ins_mem_loader_pkg;

   localparam int unsigned DataWidthDef = 8;
   localparam int unsigned AddrWidthDef = 8;

   typedef enum logic [2:0] {
      StIdle,
      StLen,
      StData,
      StCsum,
      StVerify,
      StDone,
      StError
   } state_e;

   function automatic logic state_is_busy(state_e st);
      return (st == StLen) || (st == StData) || (st == StCsum) || (st == StVerify);
   endfunction

endpackage

// File: rtl/ins_mem_loader_if.sv
// Byte-stream input and instruction-memory port bundle between the loader and its neighbours.
// The master modport is the loader side.
interface ins_mem_loader_if #(
   parameter int unsigned DATA_WIDTH = ins_mem_loader_pkg::DataWidthDef,
   parameter int unsigned ADDR_WIDTH = ins_mem_loader_pkg::AddrWidthDef
);

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  mem_wren;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] mem_q;

   modport master (
      input  in_valid, in_data, mem_q,
      output in_ready, mem_wren, mem_address, mem_data
   );

   modport slave (
      output in_valid, in_data, mem_q,
      input  in_ready, mem_wren, mem_address, mem_data
   );

endinterface

// File: rtl/ins_mem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory, then reads the
// range back and raises done or error.
module ins_mem_loader
   import ins_mem_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DataWidthDef,
   parameter int unsigned ADDR_WIDTH = AddrWidthDef,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  clock,
   input  logic                  rstN,
   input  logic                  start,
   ins_mem_loader_if.master      bus,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [DATA_WIDTH-1:0] One      = DATA_WIDTH'(1);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] idx_q, idx_d;
   logic [DATA_WIDTH-1:0] len_q, len_d;
   logic [DATA_WIDTH-1:0] wsum_q, wsum_d;
   logic [DATA_WIDTH-1:0] vsum_q, vsum_d;
   logic [DATA_WIDTH-1:0] rx_csum_q, rx_csum_d;
   logic                  wren_q, wren_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  in_ready;
   logic                  accept;

   assign in_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
   assign accept   = in_ready && bus.in_valid;

   assign bus.in_ready    = in_ready;
   assign bus.mem_wren    = wren_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_data    = data_q;
   assign busy            = state_is_busy(state_q);
   assign done            = (state_q == StDone);
   assign error           = (state_q == StError);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      wsum_d    = wsum_q;
      vsum_d    = vsum_q;
      rx_csum_d = rx_csum_q;
      wren_d    = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;

      case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d = StLen;
               idx_d   = '0;
               wsum_d  = '0;
               vsum_d  = '0;
            end
         end
         StLen: begin
            if (accept) begin
               if (bus.in_data == '0) begin
                  state_d = StError;
               end else begin
                  len_d   = bus.in_data;
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               wren_d = 1'b1;
               addr_d = BaseAddr + ADDR_WIDTH'(idx_q);
               data_d = bus.in_data;
               wsum_d = wsum_q + bus.in_data;
               idx_d  = idx_q + One;
               if (idx_q == len_q - One) begin
                  state_d = StCsum;
               end
            end
         end
         StCsum: begin
            if (accept) begin
               rx_csum_d = bus.in_data;
               idx_d     = '0;
               addr_d    = BaseAddr;
               state_d   = StVerify;
            end
         end
         StVerify: begin
            // idx_q counts VERIFY cycles; mem_q carries word idx_q-1 from cycle 1 onward.
            vsum_d = vsum_q + ((idx_q != '0) ? bus.mem_q : '0);
            if (idx_q == len_q) begin
               state_d = ((vsum_d == wsum_q) && (wsum_q == rx_csum_q)) ? StDone : StError;
            end else begin
               idx_d  = idx_q + One;
               addr_d = BaseAddr + ADDR_WIDTH'(idx_q + One);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge rstN) begin
      if (!rstN) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         len_q     <= '0;
         wsum_q    <= '0;
         vsum_q    <= '0;
         rx_csum_q <= '0;
         wren_q    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         wsum_q    <= wsum_d;
         vsum_q    <= vsum_d;
         rx_csum_q <= rx_csum_d;
         wren_q    <= wren_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

endmodule
